// File: rtl/fc_wgt_pingpong_ctrl_if.sv
// Signal bundle between the weight ping-pong controller, the memory read port,
// the weight buffer and the compute controller.
interface fc_wgt_pingpong_ctrl_if #(
    parameter int BUF_AW = 14,
    parameter int MEM_AW = 24
);
    logic              start;
    logic              mem_rd_en;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rvalid;
    logic              wgt_wr_en;
    logic              wgt_wr_bank;
    logic [BUF_AW-1:0] wgt_wr_addr;
    logic              tile_valid;
    logic              rd_bank;
    logic              tile_done;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, mem_rvalid, tile_done,
        output mem_rd_en, mem_addr, wgt_wr_en, wgt_wr_bank, wgt_wr_addr,
               tile_valid, rd_bank, busy, done, err
    );

    modport slave (
        output start, mem_rvalid, tile_done,
        input  mem_rd_en, mem_addr, wgt_wr_en, wgt_wr_bank, wgt_wr_addr,
               tile_valid, rd_bank, busy, done, err
    );
endinterface

// File: rtl/fc_wgt_pingpong_ctrl.sv
// Fills one weight bank from memory while the FC engine consumes the other,
// handing full banks over with a tile_valid / tile_done handshake.
module fc_wgt_pingpong_ctrl #(
    parameter int IFM_SIZE    = 9162,
    parameter int TILING_SIZE = 8,
    parameter int KERNEL_SIZE = 4096,
    parameter int BUF_AW      = 14,
    parameter int MEM_AW      = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fc_wgt_pingpong_ctrl_if.master bus
);
    localparam int NUM_TILES = KERNEL_SIZE / TILING_SIZE;
    localparam int TW        = $clog2(NUM_TILES + 1);
    localparam logic [BUF_AW-1:0] LAST_WORD = BUF_AW'(IFM_SIZE - 1);
    localparam logic [TW-1:0]     LAST_TILE = TW'(NUM_TILES - 1);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_FREE, FILL_DONE} state_t;

    state_t            state;
    logic [1:0]        full, full_nxt;
    logic              fill_bank, rd_bank_q;
    logic              rd_en_q, busy_q, done_q, err_q;
    logic [BUF_AW-1:0] word_cnt;
    logic [MEM_AW-1:0] mem_ptr;
    logic [TW-1:0]     tiles_filled, tiles_used;
    logic              accept, tile_end, consume, last_consume;

    assign accept       = rd_en_q & bus.mem_rvalid;
    assign tile_end     = accept && (word_cnt == LAST_WORD);
    assign consume      = bus.tile_done & full[rd_bank_q];
    assign last_consume = consume && (tiles_used == LAST_TILE);

    // Both edits apply in the same cycle; they never hit the same bank because
    // the fill side only ever targets an empty bank and consume a full one.
    always_comb begin
        full_nxt = full;
        if (consume)  full_nxt[rd_bank_q] = 1'b0;
        if (tile_end) full_nxt[fill_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            full         <= 2'b00;
            fill_bank    <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_cnt     <= '0;
            mem_ptr      <= '0;
            tiles_filled <= '0;
            tiles_used   <= '0;
        end else begin
            done_q <= 1'b0;
            full   <= full_nxt;
            if (bus.tile_done && !full[rd_bank_q]) err_q <= 1'b1;
            if (consume) begin
                rd_bank_q  <= ~rd_bank_q;
                tiles_used <= tiles_used + 1'b1;
            end
            case (state)
                IDLE: if (bus.start) begin
                    state        <= FILL;
                    rd_en_q      <= 1'b1;
                    busy_q       <= 1'b1;
                    err_q        <= 1'b0;
                    full         <= 2'b00;
                    fill_bank    <= 1'b0;
                    rd_bank_q    <= 1'b0;
                    word_cnt     <= '0;
                    mem_ptr      <= '0;
                    tiles_filled <= '0;
                    tiles_used   <= '0;
                end
                FILL: if (accept) begin
                    mem_ptr <= mem_ptr + 1'b1;
                    if (tile_end) begin
                        word_cnt     <= '0;
                        fill_bank    <= ~fill_bank;
                        tiles_filled <= tiles_filled + 1'b1;
                        if (tiles_filled == LAST_TILE) begin
                            state   <= FILL_DONE;
                            rd_en_q <= 1'b0;
                        end else if (full_nxt[~fill_bank]) begin
                            state   <= WAIT_FREE;
                            rd_en_q <= 1'b0;
                        end
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                WAIT_FREE: if (!full_nxt[fill_bank]) begin
                    state   <= FILL;
                    rd_en_q <= 1'b1;
                end
                FILL_DONE: ;
                default: begin
                    state   <= IDLE;
                    rd_en_q <= 1'b0;
                end
            endcase
            // The last consume can only land once every tile is filled, so it
            // always ends the layer from FILL_DONE.
            if (last_consume) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                rd_en_q <= 1'b0;
                state   <= IDLE;
            end
        end
    end

    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_addr    = mem_ptr;
    assign bus.wgt_wr_en   = accept;
    assign bus.wgt_wr_bank = fill_bank;
    assign bus.wgt_wr_addr = word_cnt;
    assign bus.tile_valid  = full[rd_bank_q];
    assign bus.rd_bank     = rd_bank_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_fc_wgt_pingpong_ctrl.sv
// Scenario bench for the weight ping-pong controller on a 4-tile, 4-word layer;
// buffer writes are checked against a queue of expected words.
module tb_fc_wgt_pingpong_ctrl;
    localparam int IFM_SIZE    = 4;
    localparam int TILING_SIZE = 4;
    localparam int KERNEL_SIZE = 16;
    localparam int BUF_AW      = 2;
    localparam int MEM_AW      = 8;
    localparam int NUM_TILES   = KERNEL_SIZE / TILING_SIZE;

    typedef struct {
        logic [MEM_AW-1:0] addr;
        logic              bank;
        logic [BUF_AW-1:0] waddr;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  exp_q[$];

    fc_wgt_pingpong_ctrl_if #(.BUF_AW(BUF_AW), .MEM_AW(MEM_AW)) bus ();

    fc_wgt_pingpong_ctrl #(
        .IFM_SIZE(IFM_SIZE), .TILING_SIZE(TILING_SIZE), .KERNEL_SIZE(KERNEL_SIZE),
        .BUF_AW(BUF_AW), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Expected buffer writes for a run of consecutive layer words.
    task automatic push_words(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            wr_t e;
            int  g;
            g       = first + i;
            e.addr  = MEM_AW'(g);
            e.bank  = 1'((g / IFM_SIZE) % 2);
            e.waddr = BUF_AW'(g % IFM_SIZE);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset;
        bus.start      = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.tile_done  = 1'b0;
        rst_n          = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        bus.start      = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.tile_done  = 1'b0;
        rst_n          = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.wgt_wr_en, bus.wgt_wr_bank, bus.wgt_wr_addr,
             bus.tile_valid, bus.rd_bank, bus.busy, bus.done, bus.err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd_en=%b addr=%0d wr_en=%b bank=%b waddr=%0d valid=%b rd_bank=%b busy=%b done=%b err=%b, want all 0",
                     bus.mem_rd_en, bus.mem_addr, bus.wgt_wr_en, bus.wgt_wr_bank, bus.wgt_wr_addr,
                     bus.tile_valid, bus.rd_bank, bus.busy, bus.done, bus.err);
        end
        do_reset();
    endtask

    task automatic test_stream;
        int vcnt   = 0;
        int tdones = 0;
        int dones  = 0;
        bit fin    = 0;
        do_reset();
        push_words(0, NUM_TILES * IFM_SIZE);
        pulse_start();
        for (int c = 0; c < 200 && !fin; c++) begin
            bus.mem_rvalid = 1'b1;
            vcnt = bus.tile_valid ? vcnt + 1 : 0;
            bus.tile_done = (vcnt == 3);
            if (vcnt == 3) begin
                vcnt = 0;
                tdones++;
            end
            #1;
            if (bus.wgt_wr_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra_write: got addr=%0d, want no write", bus.mem_addr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (bus.mem_addr !== e.addr || bus.wgt_wr_bank !== e.bank || bus.wgt_wr_addr !== e.waddr) begin
                        n_fail++;
                        $display("FAIL stream_write: got addr=%0d bank=%0d waddr=%0d, want addr=%0d bank=%0d waddr=%0d",
                                 bus.mem_addr, bus.wgt_wr_bank, bus.wgt_wr_addr, e.addr, e.bank, e.waddr);
                    end
                end
            end
            if (bus.done) begin
                dones++;
                fin = 1;
                n_checks++;
                if (tdones != NUM_TILES || bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_done: got tile_dones=%0d busy=%b at done, want %0d and 0",
                             tdones, bus.busy, NUM_TILES);
                end
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        bus.tile_done  = 1'b0;
        #1;
        n_checks++;
        if (dones != 1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: got done_pulses=%0d done=%b busy=%b err=%b, want 1 0 0 0",
                     dones, bus.done, bus.busy, bus.err);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_missing: got %0d writes outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int acc = 0;
        do_reset();
        push_words(0, 2 * IFM_SIZE);
        pulse_start();
        for (int c = 0; c < 40 && acc < 2 * IFM_SIZE; c++) begin
            bus.mem_rvalid = 1'b1;
            bus.tile_done  = 1'b0;
            #1;
            if (bus.wgt_wr_en) begin
                acc++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra_write: got addr=%0d, want no write", bus.mem_addr);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (bus.mem_addr !== e.addr || bus.wgt_wr_bank !== e.bank || bus.wgt_wr_addr !== e.waddr) begin
                        n_fail++;
                        $display("FAIL bp_write: got addr=%0d bank=%0d waddr=%0d, want addr=%0d bank=%0d waddr=%0d",
                                 bus.mem_addr, bus.wgt_wr_bank, bus.wgt_wr_addr, e.addr, e.bank, e.waddr);
                    end
                end
            end
            @(negedge clk);
        end
        // Both banks full: the fill must stall, and a start pulse must not disturb it.
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1'b1;
            bus.start      = (i == 1);
            #1;
            n_checks++;
            if (bus.mem_rd_en !== 1'b0 || bus.mem_addr !== MEM_AW'(8) || bus.tile_valid !== 1'b1 ||
                bus.wgt_wr_en !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_wait_free: got rd_en=%b addr=%0d valid=%b wr_en=%b busy=%b, want 0 8 1 0 1",
                         bus.mem_rd_en, bus.mem_addr, bus.tile_valid, bus.wgt_wr_en, bus.busy);
            end
            @(negedge clk);
        end
        bus.start     = 1'b0;
        bus.tile_done = 1'b1;
        @(negedge clk);
        bus.tile_done = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== MEM_AW'(8) || bus.wgt_wr_bank !== 1'b0 ||
            bus.wgt_wr_addr !== '0 || bus.rd_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_resume: got rd_en=%b addr=%0d bank=%b waddr=%0d rd_bank=%b, want 1 8 0 0 1",
                     bus.mem_rd_en, bus.mem_addr, bus.wgt_wr_bank, bus.wgt_wr_addr, bus.rd_bank);
        end
    endtask

    task automatic test_rvalid_gaps;
        int exp_ptr = 0;
        bit rv;
        do_reset();
        push_words(0, 6);
        pulse_start();
        for (int c = 0; c < 12; c++) begin
            rv = (c % 2 == 0);
            bus.mem_rvalid = rv;
            bus.tile_done  = 1'b0;
            #1;
            n_checks++;
            if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== MEM_AW'(exp_ptr)) begin
                n_fail++;
                $display("FAIL gap_addr: got rd_en=%b addr=%0d, want 1 %0d", bus.mem_rd_en, bus.mem_addr, exp_ptr);
            end
            n_checks++;
            if (bus.wgt_wr_en !== rv) begin
                n_fail++;
                $display("FAIL gap_wr_en: got wr_en=%b, want %b", bus.wgt_wr_en, rv);
            end
            if (bus.wgt_wr_en && exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (bus.mem_addr !== e.addr || bus.wgt_wr_bank !== e.bank || bus.wgt_wr_addr !== e.waddr) begin
                    n_fail++;
                    $display("FAIL gap_write: got addr=%0d bank=%0d waddr=%0d, want addr=%0d bank=%0d waddr=%0d",
                             bus.mem_addr, bus.wgt_wr_bank, bus.wgt_wr_addr, e.addr, e.bank, e.waddr);
                end
            end
            if (rv) exp_ptr++;
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL gap_missing: got %0d writes outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous;
        bit hit = 0;
        do_reset();
        pulse_start();
        for (int c = 0; c < 40 && !hit; c++) begin
            bus.mem_rvalid = 1'b1;
            hit = bus.mem_rd_en && bus.wgt_wr_bank && (bus.wgt_wr_addr == BUF_AW'(IFM_SIZE - 1));
            bus.tile_done = hit;
            #1;
            if (hit) begin
                n_checks++;
                if (bus.tile_valid !== 1'b1 || bus.rd_bank !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sim_pre: got valid=%b rd_bank=%b, want 1 0", bus.tile_valid, bus.rd_bank);
                end
            end
            @(negedge clk);
        end
        bus.tile_done = 1'b0;
        #1;
        n_checks++;
        if (!hit || bus.tile_valid !== 1'b1 || bus.rd_bank !== 1'b1 || bus.mem_rd_en !== 1'b1 ||
            bus.wgt_wr_bank !== 1'b0 || bus.mem_addr !== MEM_AW'(8) || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_post: got hit=%b valid=%b rd_bank=%b rd_en=%b bank=%b addr=%0d err=%b, want 1 1 1 1 0 8 0",
                     hit, bus.tile_valid, bus.rd_bank, bus.mem_rd_en, bus.wgt_wr_bank, bus.mem_addr, bus.err);
        end
    endtask

    task automatic test_err;
        do_reset();
        bus.tile_done = 1'b1;
        @(negedge clk);
        bus.tile_done = 1'b0;
        #1;
        n_checks++;
        if (bus.err !== 1'b1 || bus.tile_valid !== 1'b0 || bus.rd_bank !== 1'b0) begin
            n_fail++;
            $display("FAIL err_set: got err=%b valid=%b rd_bank=%b, want 1 0 0", bus.err, bus.tile_valid, bus.rd_bank);
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b, want 1", bus.err);
        end
        @(negedge clk);
        pulse_start();
        #1;
        n_checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1 || bus.mem_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b busy=%b rd_en=%b, want 0 1 1", bus.err, bus.busy, bus.mem_rd_en);
        end
    endtask

    task automatic test_mid_reset;
        bit hit  = 0;
        bit sent = 0;
        do_reset();
        pulse_start();
        for (int c = 0; c < 60 && !hit; c++) begin
            bus.mem_rvalid = 1'b1;
            bus.tile_done  = bus.tile_valid && !sent;
            if (bus.tile_valid) sent = 1;
            hit = bus.mem_rd_en && (bus.mem_addr == MEM_AW'(10));
            if (!hit) @(negedge clk);
        end
        bus.tile_done = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!hit || {bus.mem_rd_en, bus.mem_addr, bus.wgt_wr_en, bus.wgt_wr_bank, bus.wgt_wr_addr,
             bus.tile_valid, bus.rd_bank, bus.busy, bus.done, bus.err} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got hit=%b rd_en=%b addr=%0d wr_en=%b bank=%b waddr=%0d valid=%b busy=%b, want 1 then all 0",
                     hit, bus.mem_rd_en, bus.mem_addr, bus.wgt_wr_en, bus.wgt_wr_bank, bus.wgt_wr_addr,
                     bus.tile_valid, bus.busy);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.mem_rd_en, bus.mem_addr, bus.busy, bus.tile_valid, bus.wgt_wr_en} !== '0) begin
            n_fail++;
            $display("FAIL midrst_hold: got rd_en=%b addr=%0d busy=%b valid=%b wr_en=%b, want all 0",
                     bus.mem_rd_en, bus.mem_addr, bus.busy, bus.tile_valid, bus.wgt_wr_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        exp_q.delete();
        push_words(0, IFM_SIZE);
        pulse_start();
        for (int c = 0; c < IFM_SIZE; c++) begin
            bus.mem_rvalid = 1'b1;
            #1;
            n_checks++;
            if (!bus.wgt_wr_en || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL midrst_restart: got wr_en=%b outstanding=%0d, want 1 and >0", bus.wgt_wr_en, exp_q.size());
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.mem_addr !== e.addr || bus.wgt_wr_bank !== e.bank || bus.wgt_wr_addr !== e.waddr) begin
                    n_fail++;
                    $display("FAIL midrst_write: got addr=%0d bank=%0d waddr=%0d, want addr=%0d bank=%0d waddr=%0d",
                             bus.mem_addr, bus.wgt_wr_bank, bus.wgt_wr_addr, e.addr, e.bank, e.waddr);
                end
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_rvalid_gaps();
        test_simultaneous();
        test_err();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
